// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (IDLE / GRANT / TURN), 2-bit encoding
//   BEAT_W      : width of the per-grant beat counter
//   STAT_W      : width of each optional per-requester write-beat statistic
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int BEAT_W = 8;
  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   last  : index of the previous grantee; the search starts at last+1
//   valid : at least one request is set
//   idx   : first set request at or after last+1, wrapping around
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest set request
  // (smallest offset after last) is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter feeding NREQ write requesters into
// one FIFO write port, with bursts of up to BURST_MAX beats per grant.
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   req          : per-requester request, held while its data is valid
//   req_data     : requester i data at [i*DW +: DW]
//   gnt          : registered one-hot grant (zero when nobody is granted)
//   ack          : one-hot, beat written this cycle; requester advances on it
//   fifo_full    : FIFO full flag, stalls the current burst
//   fifo_wr      : FIFO write strobe
//   fifo_data    : FIFO data_in, holds its last value outside a grant
//   owner        : registered index of the current or last grantee
//   busy         : high while a grant is active
//   beat_cnt     : per-requester saturating write-beat counters, present
//                  only when FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int BURST_MAX = 8,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [DW-1:0]          fifo_data,
  output logic [IW-1:0]          owner,
`ifdef FIFO_ARB_STATS_EN
  output logic [NREQ*STAT_W-1:0] beat_cnt,
`endif
  output logic                   busy
);

  logic [NREQ-1:0][DW-1:0] lane_data;
  arb_state_e              state, state_nxt;
  logic [BEAT_W-1:0]       beat;
  logic [DW-1:0]           data_q;
  logic                    pick_vld;
  logic [IW-1:0]           pick_idx;
  logic                    own_req, last_beat, exit_grant;

  assign lane_data = req_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign busy       = (state == GRANT);
  assign own_req    = req[owner];
  assign fifo_wr    = busy && own_req && !fifo_full;
  assign last_beat  = (beat == BEAT_W'(BURST_MAX - 1));
  // A dropped request ends the burst even while the FIFO is full.
  assign exit_grant = !own_req || (fifo_wr && last_beat);
  assign fifo_data  = busy ? lane_data[owner] : data_q;

  always_comb begin
    ack = '0;
    if (fifo_wr) ack[owner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)   state_nxt = GRANT;
      GRANT:   if (exit_grant) state_nxt = TURN;
      TURN:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // owner resets to NREQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt    <= '0;
      owner  <= IW'(NREQ - 1);
      beat   <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          owner <= pick_idx;
          gnt   <= NREQ'(1) << pick_idx;
          beat  <= '0;
        end
        GRANT: begin
          data_q <= lane_data[owner];
          if (exit_grant)   gnt  <= '0;
          else if (fifo_wr) beat <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     cnt <= '0;
      else if (ack[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign beat_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter.
// Requesters are modelled as queues of data beats; a transaction-level
// round-robin model predicts the burst sequence and the written data stream.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ = 4, DW = 32, BURST_MAX = 8, IW = 2;

  logic                clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0]     req = '0, gnt, ack;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic                fifo_full = 1'b0, fifo_wr, busy;
  logic [DW-1:0]       fifo_data;
  logic [IW-1:0]       owner;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data), .owner(owner),
`ifdef FIFO_ARB_STATS_EN
    .beat_cnt(beat_cnt),
`endif
    .busy(busy));

  int n_cmp = 0, n_bad = 0;

  // requester side
  logic [DW-1:0] q [NREQ][$];
  logic [DW-1:0] lane_val [NREQ];
  int            m_owner;

  // observed log
  int            b_own[$], b_len[$], gaps[$], w_who[$];
  logic [DW-1:0] w_data[$];
  int            first_gnt_cyc, first_wr_cyc, last_gnt_cyc, proto_err, timed_out;

  // expected from the model
  int            e_own[$], e_len[$], e_who[$];
  logic [DW-1:0] e_data[$];

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = lane_val[i];
  endtask

  task automatic apply_reset();
    rst = 1'b0; req = '0; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin lane_val[i] = '0; q[i].delete(); end
    drive_lanes();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_owner = NREQ - 1;
  endtask

  task automatic fill(input int i, input int n);
    for (int k = 0; k < n; k++) q[i].push_back({8'(i), 24'($urandom)});
  endtask

  // Round-robin at burst granularity: next non-empty requester after the
  // last owner sends min(remaining, BURST_MAX) beats.
  task automatic plan();
    int len[NREQ];
    int pos[NREQ];
    int found, n, c;
    e_own.delete(); e_len.delete(); e_data.delete(); e_who.delete();
    for (int i = 0; i < NREQ; i++) begin len[i] = q[i].size(); pos[i] = 0; end
    while (1) begin
      found = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_owner + k) % NREQ;
        if (found < 0 && len[c] > 0) found = c;
      end
      if (found < 0) break;
      n = (len[found] < BURST_MAX) ? len[found] : BURST_MAX;
      e_own.push_back(found); e_len.push_back(n);
      for (int j = 0; j < n; j++) begin
        e_data.push_back(q[found][pos[found] + j]);
        e_who.push_back(found);
      end
      pos[found] += n; len[found] -= n; m_owner = found;
    end
  endtask

  // Drives queues into the DUT; inputs change on the falling edge and
  // outputs are sampled 1ns later, well before the next rising edge.
  task automatic run_traffic(input int full_pct, input int full_from,
                             input int full_cnt, input int max_cyc);
    int cyc = 0, quiet = 0, gap = 0;
    logic [NREQ-1:0] prev = '0;
    logic any;
    b_own.delete(); b_len.delete(); gaps.delete(); w_data.delete(); w_who.delete();
    first_gnt_cyc = -1; first_wr_cyc = -1; last_gnt_cyc = -1;
    proto_err = 0; timed_out = 1;
    while (cyc < max_cyc) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() > 0) lane_val[i] = q[i][0];
        req[i] = (q[i].size() > 0);
      end
      drive_lanes();
      fifo_full = (cyc >= full_from && cyc < full_from + full_cnt) ||
                  ($urandom_range(99) < full_pct);
      #1;
      if (gnt != '0 && prev == '0) begin
        if (b_own.size() > 0) gaps.push_back(gap);
        b_own.push_back(idx_of(gnt)); b_len.push_back(0);
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
      if (gnt != '0) begin last_gnt_cyc = cyc; gap = 0; end
      else gap++;
      if (busy !== (gnt != '0)) proto_err++;
      if (gnt != '0 && !$onehot(gnt)) proto_err++;
      if (fifo_wr === 1'b1) begin
        if (ack !== gnt || fifo_full) proto_err++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        w_data.push_back(fifo_data); w_who.push_back(idx_of(ack));
        if (b_len.size() > 0) b_len[b_len.size()-1]++;
      end else if (ack !== '0) proto_err++;
      for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) void'(q[i].pop_front());
      prev = gnt;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) any = 1'b1;
      if (!any && gnt == '0) quiet++; else quiet = 0;
      if (quiet >= 3) begin timed_out = 0; break; end
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '1;
    @(negedge clk); #1;
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset.gnt got=%b want=0", gnt); end
    n_cmp++; if (fifo_wr !== 1'b0) begin n_bad++; $display("FAIL reset.fifo_wr got=%b want=0", fifo_wr); end
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL reset.ack got=%b want=0", ack); end
    n_cmp++; if (owner !== IW'(NREQ-1)) begin n_bad++; $display("FAIL reset.owner got=%0d want=%0d", owner, NREQ-1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy got=%b want=0", busy); end
    n_cmp++; if (fifo_data !== '0) begin n_bad++; $display("FAIL reset.fifo_data got=%h want=0", fifo_data); end
    req = '0;
  endtask

  task automatic test_single();
    apply_reset();
    fill(0, 3); plan();
    run_traffic(0, 0, 0, 50);
    n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL single.timeout got=%0d want=0", timed_out); end
    n_cmp++; if (b_own.size() !== 1 || b_own[0] !== 0 || b_len[0] !== 3) begin
      n_bad++; $display("FAIL single.burst got=%0d bursts own=%0d len=%0d want 1 own=0 len=3", b_own.size(), b_own[0], b_len[0]); end
    for (int k = 0; k < e_data.size(); k++) begin
      n_cmp++; if (w_data[k] !== e_data[k]) begin n_bad++; $display("FAIL single.data[%0d] got=%h want=%h", k, w_data[k], e_data[k]); end
    end
    n_cmp++; if (first_gnt_cyc !== 2) begin n_bad++; $display("FAIL single.gnt_latency got=%0d want=2", first_gnt_cyc); end
    n_cmp++; if (first_wr_cyc !== 2) begin n_bad++; $display("FAIL single.wr_latency got=%0d want=2", first_wr_cyc); end
    // 3 writes in cycles 2..4, the drop is seen in cycle 5, then TURN and IDLE.
    n_cmp++; if (last_gnt_cyc !== 5) begin n_bad++; $display("FAIL single.grant_end got=%0d want=5", last_gnt_cyc); end
    n_cmp++; if (fifo_data !== e_data[2]) begin n_bad++; $display("FAIL single.data_hold got=%h want=%h", fifo_data, e_data[2]); end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL single.protocol got=%0d want=0", proto_err); end
  endtask

  task automatic test_all_req();
    int want[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NREQ; i++) fill(i, 2*BURST_MAX);
    plan();
    run_traffic(0, 0, 0, 400);
    n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL allreq.timeout got=%0d want=0", timed_out); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (b_own[k] !== want[k] || b_len[k] !== BURST_MAX) begin
        n_bad++; $display("FAIL allreq.burst[%0d] got own=%0d len=%0d want own=%0d len=%0d", k, b_own[k], b_len[k], want[k], BURST_MAX); end
    end
    n_cmp++; if (b_own.size() !== e_own.size()) begin n_bad++; $display("FAIL allreq.nburst got=%0d want=%0d", b_own.size(), e_own.size()); end
    for (int k = 0; k < e_data.size(); k++) begin
      n_cmp++; if (w_data[k] !== e_data[k] || w_who[k] !== e_who[k]) begin
        n_bad++; $display("FAIL allreq.data[%0d] got=%h/%0d want=%h/%0d", k, w_data[k], w_who[k], e_data[k], e_who[k]); end
    end
    // grant drops for the TURN cycle plus the IDLE arbitration cycle
    for (int k = 0; k < gaps.size(); k++) begin
      n_cmp++; if (gaps[k] !== 2) begin n_bad++; $display("FAIL allreq.gap[%0d] got=%0d want=2", k, gaps[k]); end
    end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL allreq.protocol got=%0d want=0", proto_err); end
  endtask

  task automatic test_stall();
    apply_reset();
    fill(2, BURST_MAX); plan();
    run_traffic(0, 4, 5, 200);
    n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL stall.timeout got=%0d want=0", timed_out); end
    n_cmp++; if (b_own.size() !== 1 || b_own[0] !== 2 || b_len[0] !== BURST_MAX) begin
      n_bad++; $display("FAIL stall.burst got=%0d bursts own=%0d len=%0d want 1 own=2 len=%0d", b_own.size(), b_own[0], b_len[0], BURST_MAX); end
    // writes in 2,3 then 5 stalled cycles 4..8, remaining 6 writes in 9..14
    n_cmp++; if (last_gnt_cyc !== 14) begin n_bad++; $display("FAIL stall.grant_end got=%0d want=14", last_gnt_cyc); end
    for (int k = 0; k < e_data.size(); k++) begin
      n_cmp++; if (w_data[k] !== e_data[k]) begin n_bad++; $display("FAIL stall.data[%0d] got=%h want=%h", k, w_data[k], e_data[k]); end
    end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL stall.protocol got=%0d want=0", proto_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lane_val[1] = 32'hA5A5_0001; drive_lanes(); req = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      n_cmp++; if (fifo_wr !== 1'b1) begin n_bad++; $display("FAIL rstmid.beat%0d got=%b want=1", b, fifo_wr); end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (gnt !== '0 || fifo_wr !== 1'b0 || ack !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid.abort got gnt=%b wr=%b ack=%b busy=%b want 0", gnt, fifo_wr, ack, busy); end
    n_cmp++; if (owner !== IW'(NREQ-1) || fifo_data !== '0) begin
      n_bad++; $display("FAIL rstmid.state got owner=%0d data=%h want %0d/0", owner, fifo_data, NREQ-1); end
    req = 4'b0100; lane_val[2] = 32'h0000_0C02; drive_lanes();
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rstmid.release got=%b want=0", gnt); end
    @(negedge clk); #1;
    n_cmp++; if (gnt !== 4'b0100 || owner !== 2'd2) begin
      n_bad++; $display("FAIL rstmid.regrant got gnt=%b owner=%0d want 0100/2", gnt, owner); end
    req = '0;
  endtask

  task automatic test_drop_full();
    apply_reset();
    lane_val[3] = 32'h3333_0000; drive_lanes(); req = 4'b1000;
    @(negedge clk); #1;
    n_cmp++; if (fifo_wr !== 1'b1 || ack !== 4'b1000) begin n_bad++; $display("FAIL dropfull.first got wr=%b ack=%b want 1/1000", fifo_wr, ack); end
    @(negedge clk); req = '0; fifo_full = 1'b1; #1;
    n_cmp++; if (fifo_wr !== 1'b0 || ack !== '0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL dropfull.nowrite got wr=%b ack=%b busy=%b want 0/0/1", fifo_wr, ack, busy); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || gnt !== '0) begin n_bad++; $display("FAIL dropfull.turn got busy=%b gnt=%b want 0/0", busy, gnt); end
    fifo_full = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (gnt !== '0 || fifo_wr !== 1'b0) begin n_bad++; $display("FAIL dropfull.idle got gnt=%b wr=%b want 0/0", gnt, fifo_wr); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREQ; i++) fill(i, $urandom_range(0, 20));
      plan();
      run_traffic(25, 0, 0, 3000);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL random%0d.timeout got=%0d want=0", r, timed_out); end
      n_cmp++; if (b_own.size() !== e_own.size()) begin n_bad++; $display("FAIL random%0d.nburst got=%0d want=%0d", r, b_own.size(), e_own.size()); end
      for (int k = 0; k < e_own.size(); k++) begin
        n_cmp++; if (b_own[k] !== e_own[k] || b_len[k] !== e_len[k]) begin
          n_bad++; $display("FAIL random%0d.burst[%0d] got own=%0d len=%0d want own=%0d len=%0d", r, k, b_own[k], b_len[k], e_own[k], e_len[k]); end
      end
      for (int k = 0; k < e_data.size(); k++) begin
        n_cmp++; if (w_data[k] !== e_data[k] || w_who[k] !== e_who[k]) begin
          n_bad++; $display("FAIL random%0d.data[%0d] got=%h/%0d want=%h/%0d", r, k, w_data[k], w_who[k], e_data[k], e_who[k]); end
      end
      n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL random%0d.protocol got=%0d want=0", r, proto_err); end
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    fill(1, 300); plan();
    run_traffic(0, 0, 0, 2000);
    for (int i = 0; i < NREQ; i++) begin
      n_cmp++; if (beat_cnt[i*STAT_W +: STAT_W] !== ((i == 1) ? 16'd300 : 16'd0)) begin
        n_bad++; $display("FAIL stats.cnt[%0d] got=%0d want=%0d", i, beat_cnt[i*STAT_W +: STAT_W], (i == 1) ? 300 : 0); end
    end
    @(negedge clk);
    force dut.g_stat[1].cnt = 16'hFFFE;
    @(negedge clk);
    release dut.g_stat[1].cnt;
    fill(1, 3); plan();
    run_traffic(0, 0, 0, 100);
    n_cmp++; if (beat_cnt[1*STAT_W +: STAT_W] !== 16'hFFFF) begin
      n_bad++; $display("FAIL stats.sat got=%h want=ffff", beat_cnt[1*STAT_W +: STAT_W]); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_stall();
    test_reset_mid();
    test_drop_full();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
